// File: rtl/fetch_align.sv
// fetch_align
//   Instruction fetch alignment buffer between instruction memory and decode.
//   Accepts word-aligned 32-bit fetch data, splits it into RV32IC instructions
//   (16-bit compressed or 32-bit, including 32-bit ones straddling two words)
//   and hands out one instruction per handshake together with its PC.
//
// Ports
//   clk            rising-edge clock
//   reset_n        synchronous active-low reset
//   flush          redirect request, overrides all other activity in its cycle
//   flush_pc       redirect target (bit 0 ignored)
//   fetch_addr     word address of the next word to accept ([1:0] always 0)
//   in_valid       in_data holds the word at fetch_addr
//   in_ready       buffer can accept a word (depends on registered state only)
//   in_data        fetched word, little-endian halfwords
//   out_valid      out_instr / out_pc valid
//   out_ready      downstream accepts
//   out_instr      instruction; compressed ones zero-extended from [15:0]
//   out_compressed 1 = 16-bit instruction (decompressor enable)
//   out_pc         address of out_instr
module fetch_align #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic [ADDR_WIDTH-1:0] flush_pc,
    output logic [ADDR_WIDTH-1:0] fetch_addr,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_instr,
    output logic                  out_compressed,
    output logic [ADDR_WIDTH-1:0] out_pc
);

    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] HALF_MASK = ~ADDR_WIDTH'(1);

    // Drop n halfwords from the bottom of the buffer.
    function automatic logic [47:0] shift_hw(input logic [47:0] b, input logic [1:0] n);
        case (n)
            2'd1:    return {16'h0000, b[47:16]};
            2'd2:    return {32'h0000_0000, b[47:32]};
            default: return b;
        endcase
    endfunction

    // Append a fetched word (or only its upper halfword) at halfword slot pos.
    // pos is at most 1 because a push is only accepted with cnt <= 1.
    function automatic logic [47:0] insert_word(input logic [47:0] b,
                                                input logic [1:0]  pos,
                                                input logic        half,
                                                input logic [31:0] w);
        logic [47:0] r;
        r = b;
        if (half) begin
            if (pos == 2'd0) r[15:0]  = w[31:16];
            else             r[31:16] = w[31:16];
        end else begin
            if (pos == 2'd0) r[31:0]  = w;
            else             r[47:16] = w;
        end
        return r;
    endfunction

    logic [47:0]           hb;
    logic [1:0]            cnt;
    logic                  skip;
    logic [ADDR_WIDTH-1:0] pc;

    logic [15:0] hw0;
    logic [15:0] hw1;
    logic        is_c;
    logic        avail;
    logic        push;
    logic [1:0]  pop_n;
    logic [1:0]  push_n;
    logic [1:0]  base;
    logic [47:0] hb_shift;
    logic [47:0] hb_next;

    always_comb begin
        hw0      = hb[15:0];
        hw1      = hb[31:16];
        is_c     = (hw0[1:0] != 2'b11);
        avail    = is_c ? (cnt != 2'd0) : (cnt >= 2'd2);

        out_valid      = avail & ~flush;
        out_compressed = out_valid & is_c;
        // Gate with out_valid so the outputs read zero when nothing is presented.
        if (!out_valid)  out_instr = 32'h0000_0000;
        else if (is_c)   out_instr = {16'h0000, hw0};
        else             out_instr = {hw1, hw0};
        out_pc   = pc;

        in_ready = (cnt <= 2'd1);
        push     = in_valid & in_ready;
        pop_n    = (out_valid & out_ready) ? (is_c ? 2'd1 : 2'd2) : 2'd0;
        push_n   = push ? (skip ? 2'd1 : 2'd2) : 2'd0;
        // Slot where new halfwords land once the popped ones are gone.
        base     = cnt - pop_n;

        hb_shift = shift_hw(hb, pop_n);
        hb_next  = push ? insert_word(hb_shift, base, skip, in_data) : hb_shift;
    end

    // Control state: the only registers that see reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt        <= 2'd0;
            skip       <= RESET_PC[1];
            fetch_addr <= RESET_PC & WORD_MASK;
            pc         <= RESET_PC;
        end else if (flush) begin
            cnt        <= 2'd0;
            fetch_addr <= flush_pc & WORD_MASK;
            pc         <= flush_pc & HALF_MASK;
            // A redirect into the upper halfword drops the lower half of the next word.
            skip       <= flush_pc[1];
        end else begin
            cnt <= base + push_n;
            pc  <= pc + ADDR_WIDTH'({pop_n, 1'b0});
            if (push) begin
                fetch_addr <= fetch_addr + ADDR_WIDTH'(4);
                skip       <= 1'b0;
            end
        end
    end

    // Halfword data: validity is tracked entirely by cnt, so no reset needed.
    always_ff @(posedge clk) begin
        hb <= hb_next;
    end

endmodule

// File: tb/tb_fetch_align.sv
module tb_fetch_align;

    logic        clk;
    logic        reset_n;
    logic        flush;
    logic [31:0] flush_pc;
    logic [31:0] fetch_addr;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_compressed;
    logic [31:0] out_pc;

    int checks = 0;
    int errors = 0;

    fetch_align #(
        .ADDR_WIDTH (32),
        .RESET_PC   (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .flush          (flush),
        .flush_pc       (flush_pc),
        .fetch_addr     (fetch_addr),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_compressed (out_compressed),
        .out_pc         (out_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        flush;
        logic [31:0] fpc;
        logic        iv;
        logic [31:0] din;
        logic        ordy;
        logic        ov;
        logic [31:0] instr;
        logic        c;
        logic [31:0] pc;
        logic        ir;
        logic [31:0] fa;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic ov, input logic [31:0] instr,
                           input logic c, input logic [31:0] pc, input logic ir,
                           input logic [31:0] fa);
        chk({tag, " out_valid"},      {31'b0, out_valid},      {31'b0, ov});
        chk({tag, " out_instr"},      out_instr,               instr);
        chk({tag, " out_compressed"}, {31'b0, out_compressed}, {31'b0, c});
        chk({tag, " out_pc"},         out_pc,                  pc);
        chk({tag, " in_ready"},       {31'b0, in_ready},       {31'b0, ir});
        chk({tag, " fetch_addr"},     fetch_addr,              fa);
    endtask

    // Drive inputs at the falling edge, check just after, let the rising edge commit.
    task automatic drive(input logic fl, input logic [31:0] fpc, input logic iv,
                         input logic [31:0] din, input logic ordy);
        @(negedge clk);
        flush     = fl;
        flush_pc  = fpc;
        in_valid  = iv;
        in_data   = din;
        out_ready = ordy;
        #1;
    endtask

    initial begin
        reset_n = 1'b0; flush = 1'b0; flush_pc = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        // Two compressed in one word (pc 0)
        vecs.push_back('{1'b0, 32'h0, 1'b1, 32'h4585_4501, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,   1'b1, 32'h0});
        vecs.push_back('{1'b0, 32'h0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_4501, 1'b1, 32'h0,   1'b0, 32'h4});
        vecs.push_back('{1'b0, 32'h0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_4585, 1'b1, 32'h2,   1'b1, 32'h4});
        vecs.push_back('{1'b0, 32'h0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b0, 32'h4,   1'b1, 32'h4});
        // Flush back to 0, then straddling 32-bit instruction
        vecs.push_back('{1'b1, 32'h0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b0, 32'h4,   1'b1, 32'h4});
        vecs.push_back('{1'b0, 32'h0, 1'b1, 32'h0093_4501, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,   1'b1, 32'h0});
        vecs.push_back('{1'b0, 32'h0, 1'b1, 32'h4585_0010, 1'b1, 1'b1, 32'h0000_4501, 1'b1, 32'h0,   1'b0, 32'h4});
        vecs.push_back('{1'b0, 32'h0, 1'b1, 32'h4585_0010, 1'b1, 1'b0, 32'h0,         1'b0, 32'h2,   1'b1, 32'h4});
        vecs.push_back('{1'b0, 32'h0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0010_0093, 1'b0, 32'h2,   1'b0, 32'h8});
        vecs.push_back('{1'b0, 32'h0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_4585, 1'b1, 32'h6,   1'b1, 32'h8});
        vecs.push_back('{1'b0, 32'h0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b0, 32'h8,   1'b1, 32'h8});
        // Build cnt=3, then misaligned flush to 0x103
        vecs.push_back('{1'b0, 32'h0, 1'b1, 32'h4585_4501, 1'b0, 1'b0, 32'h0,         1'b0, 32'h8,   1'b1, 32'h8});
        vecs.push_back('{1'b0, 32'h0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_4501, 1'b1, 32'h8,   1'b0, 32'hC});
        vecs.push_back('{1'b0, 32'h0, 1'b1, 32'h0001_0001, 1'b0, 1'b1, 32'h0000_4585, 1'b1, 32'hA,   1'b1, 32'hC});
        vecs.push_back('{1'b1, 32'h103, 1'b1, 32'h1111_2222, 1'b1, 1'b0, 32'h0,       1'b0, 32'hA,   1'b0, 32'h10});
        vecs.push_back('{1'b0, 32'h0, 1'b1, 32'h4501_ABCD, 1'b1, 1'b0, 32'h0,         1'b0, 32'h102, 1'b1, 32'h100});
        vecs.push_back('{1'b0, 32'h0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_4501, 1'b1, 32'h102, 1'b1, 32'h104});
        vecs.push_back('{1'b0, 32'h0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b0, 32'h104, 1'b1, 32'h104});
        // Backpressure: hold for 3 cycles with in_valid high, then drain
        vecs.push_back('{1'b0, 32'h0, 1'b1, 32'h4585_4501, 1'b0, 1'b0, 32'h0,         1'b0, 32'h104, 1'b1, 32'h104});
        vecs.push_back('{1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0000_4501, 1'b1, 32'h104, 1'b0, 32'h108});
        vecs.push_back('{1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0000_4501, 1'b1, 32'h104, 1'b0, 32'h108});
        vecs.push_back('{1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0000_4501, 1'b1, 32'h104, 1'b0, 32'h108});
        vecs.push_back('{1'b0, 32'h0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_4501, 1'b1, 32'h104, 1'b0, 32'h108});
        vecs.push_back('{1'b0, 32'h0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_4585, 1'b1, 32'h106, 1'b1, 32'h108});
        vecs.push_back('{1'b0, 32'h0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b0, 32'h108, 1'b1, 32'h108});
        // 0x0000 halfwords pass through as compressed
        vecs.push_back('{1'b0, 32'h0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 32'h0,         1'b0, 32'h108, 1'b1, 32'h108});
        vecs.push_back('{1'b0, 32'h0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0,         1'b1, 32'h108, 1'b0, 32'h10C});
        vecs.push_back('{1'b0, 32'h0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0,         1'b1, 32'h10A, 1'b1, 32'h10C});
        vecs.push_back('{1'b0, 32'h0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b0, 32'h10C, 1'b1, 32'h10C});
        // Address wrap: redirect to 0xFFFF_FFFE
        vecs.push_back('{1'b1, 32'hFFFF_FFFE, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h10C, 1'b1, 32'h10C});
        vecs.push_back('{1'b0, 32'h0, 1'b1, 32'h4501_1234, 1'b1, 1'b0, 32'h0,         1'b0, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFC});
        vecs.push_back('{1'b0, 32'h0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_4501, 1'b1, 32'hFFFF_FFFE, 1'b1, 32'h0});
        vecs.push_back('{1'b0, 32'h0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b0, 32'h0,   1'b1, 32'h0});

        // Reset held for two rising edges
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk_all("reset", 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].flush, vecs[i].fpc, vecs[i].iv, vecs[i].din, vecs[i].ordy);
            chk_all($sformatf("v%0d", i), vecs[i].ov, vecs[i].instr, vecs[i].c,
                    vecs[i].pc, vecs[i].ir, vecs[i].fa);
        end

        // Reset mid-operation with cnt=3 and out_valid=1
        drive(1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 32'h4585_4501, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        drive(1'b0, 32'h0, 1'b1, 32'h0001_0001, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk_all("midrst pre", 1'b1, 32'h0000_4585, 1'b1, 32'h2, 1'b0, 32'h8);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        #1;
        chk_all("midrst", 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0);
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
            chk_all($sformatf("postrst%0d", k), 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_align.md
# fetch_align

Instruction fetch alignment buffer sitting between instruction memory and the decode stage. It accepts 32-bit word-aligned fetch data, splits it into a stream of RV32IC instructions, and presents one instruction per handshake with its PC. A 16-bit compressed instruction comes out with the compressed flag set, which drives the decompressor's `enable`. A 32-bit instruction comes out whole, including one that straddles two memory words. It also handles PC redirects (flush) to any halfword-aligned address.

## Interface
- `ADDR_WIDTH`, 32, PC/fetch address width
- `RESET_PC`, 32'h0000_0000, PC after reset; must be halfword-aligned

- `clk`  in  1  single clock, rising edge
- `reset_n`  in  1  synchronous, active-low reset (one clock; reset is synchronous and active-low)
- `flush`  in  1  redirect request; has priority over all other activity in its cycle
- `flush_pc`  in  ADDR_WIDTH  redirect target; bit 0 ignored
- `fetch_addr`  out  ADDR_WIDTH  word address of the next word to accept; bits [1:0] are always 0
- `in_valid`  in  1  `in_data` holds the word at `fetch_addr`
- `in_ready`  out  1  buffer can accept a word
- `in_data`  in  32  fetched word, little-endian halfwords
- `out_valid`  out  1  `out_instr` and `out_pc` are valid
- `out_ready`  in  1  downstream accepts
- `out_instr`  out  32  instruction; when compressed, [15:0] holds the halfword and [31:16]=0
- `out_compressed`  out  1  1 = 16-bit instruction (decompress `enable`)
- `out_pc`  out  ADDR_WIDTH  address of `out_instr`

## Operation
- **State.**
  - 48-bit halfword buffer `hb`; hw0 (bits [15:0]) is the oldest halfword.
  - `cnt` in 0..3 counts valid halfwords.
  - `skip` flag, `fetch_addr` register, `pc` register.
- **Word push.** Occurs when `in_valid & in_ready`; `in_ready = (cnt <= 1)` from registered state only.
  - Normal push: the word is appended at halfword position `cnt - pop`, and `cnt` increases by 2.
  - If `skip=1`: only `in_data[31:16]` is appended, `cnt` increases by 1, and `skip` clears.
  - `fetch_addr` increases by 4 on every push.
- **Instruction classification.**
  - `hw0[1:0] != 2'b11`: compressed. Needs `cnt >= 1`; pop = 1 halfword.
  - Otherwise: 32-bit, `out_instr = {hw1, hw0}`. Needs `cnt >= 2`; pop = 2 halfwords.
- **Output.**
  - `out_valid` = (needed halfwords present) & !flush.
  - On `out_valid & out_ready`: the buffer shifts down by pop, `cnt -= pop`, `pc += 2*pop`.
  - Push and pop in the same cycle combine: `cnt_next = cnt - pop + push_count`. `cnt` never exceeds 3.
- **Flush.** In the flush cycle:
  - Any push or pop is discarded; `cnt` goes to 0.
  - `fetch_addr` loads `{flush_pc[AW-1:2], 2'b00}`.
  - `pc` loads `{flush_pc[AW-1:1], 1'b0}`.
  - `skip` loads `flush_pc[1]`.
- **Reset.** Sets `cnt=0`, `skip=RESET_PC[1]`, `fetch_addr=RESET_PC & ~3`, `pc=RESET_PC`. Reset takes priority over flush.
- **No validity checks.** A halfword of 0x0000 (illegal C encoding) is passed through as compressed and is not flagged here.

## Timing
- **Reset values** (sampled at the next edge after `reset_n=0`):
  - `out_valid=0`, `in_ready=1`, `out_instr=0`, `out_compressed=0`.
  - `out_pc=RESET_PC`, `fetch_addr=RESET_PC & ~3`.
- **Latency.** A word pushed in cycle N can produce `out_valid` in cycle N+1. There is no combinational path from `in_*` to `out_*`.
- **`in_ready`.** Depends only on registered `cnt`; it does not depend on `out_ready` or `flush`.
- **Hold under backpressure.** While `out_valid & !out_ready`, `out_instr`, `out_compressed` and `out_pc` stay stable unless `flush` is asserted.
- **Straddling 32-bit instruction.** With `cnt=1` and `hw0[1:0]=11`, `out_valid` stays 0 until the next word is pushed, then rises in the following cycle.
- **Flush recovery.** `out_valid=0` in the flush cycle and in the cycle after it. The first post-flush word can be accepted in the cycle after flush.
- **Address wrap.** `fetch_addr` and `pc` wrap modulo 2^ADDR_WIDTH with no error.

## Test plan
- **Reset.** `reset_n=0` for 2 cycles → `fetch_addr=0x0`, `in_ready=1`, `out_valid=0`, `out_pc=0x0`.
- **Two compressed in one word.** Push word `0x4585_4501`, `out_ready=1`:
  - 1st output: pc 0x0, `out_instr=0x0000_4501`, compressed 1.
  - 2nd output: pc 0x2, `out_instr=0x0000_4585`, compressed 1.
  - Then `out_valid=0`.
- **Straddling 32-bit instruction.** Push `0x0093_4501`, then `0x4585_0010`:
  - pc 0x0, `0x0000_4501`, compressed 1.
  - pc 0x2, `0x0010_0093`, compressed 0.
  - pc 0x6, `0x0000_4585`, compressed 1.
- **Misaligned flush.** With `cnt=3`, assert `flush` with `flush_pc=0x0000_0103` → next cycle `fetch_addr=0x100`, `out_pc=0x102`, `cnt=0`.
  - Then push `0x4501_ABCD` → output pc 0x102, `0x0000_4501`; 0xABCD is dropped.
- **Backpressure.** Push `0x4585_4501`, hold `out_ready=0` for 3 cycles:
  - `out_pc=0x0` and `out_instr=0x4501` stay stable throughout.
  - `in_ready=0` throughout (`cnt=2`).
  - The 4th cycle transfers.
- **Reset mid-operation.** With `cnt=3` and `out_valid=1`, pulse `reset_n=0` for 1 cycle → next cycle all outputs equal their reset values, and no stale instruction appears afterwards.
